// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arb_pkg
// Brief    : Shared types and constants for the data memory arbiter.
// Revision : 1.0
// ============================================================================
package data_mem_arb_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    localparam logic REQ_CORE   = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter_if
// Brief    : Request/response ports of both requesters plus the data_mem port.
// Revision : 1.0
// ============================================================================
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic              mem_wrt_en;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    logic              busy;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  mem_read_data,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_wrt_en, mem_address, mem_write_data,
        output busy
    );

    // Requesters and memory side
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output mem_read_data,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_wrt_en, mem_address, mem_write_data,
        input  busy
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Combinational two-way round-robin pick; favours the port that
//            did not win last time when both request.
// Revision : 1.0
// ============================================================================
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_id,
    output logic       grant_any
);
    import data_mem_arb_pkg::*;

    always_comb begin
        grant_any = |valid;
        grant_id  = REQ_CORE;
        if (valid == 2'b11) begin
            grant_id = ~last_grant;
        end else if (valid[1]) begin
            grant_id = REQ_LOADER;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Brief    : Grants one of two requesters, performs a single data_mem access
//            and returns a one-cycle response pulse to the winner.
// Revision : 1.0
// ============================================================================
module data_mem_arbiter #(
    parameter int ADDR_W = data_mem_arb_pkg::ADDR_W,
    parameter int DATA_W = data_mem_arb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_arbiter_if.slave bus
);
    import data_mem_arb_pkg::*;

    arb_state_t        state;
    arb_state_t        state_nx;
    logic              last_grant;
    logic              grant_id;
    logic              grant_any;
    logic              accept;
    logic              in_access;

    logic              lat_we;
    logic              lat_id;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              rsp0_valid;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic [DATA_W-1:0] rsp1_rdata;

    rr_arbiter2 u_rr (
        .valid      ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant),
        .grant_id   (grant_id),
        .grant_any  (grant_any)
    );

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (grant_any) begin
                    accept   = 1'b1;
                    state_nx = ARB_ACCESS;
                end
            end
            ARB_ACCESS: state_nx = ARB_IDLE;
            default:    state_nx = ARB_IDLE;
        endcase
    end

    // Async reset drops in_access at once, so an aborted store never commits.
    assign in_access          = (state == ARB_ACCESS);
    assign bus.busy           = in_access;
    assign bus.req0_ready     = accept & (grant_id == REQ_CORE);
    assign bus.req1_ready     = accept & (grant_id == REQ_LOADER);
    assign bus.mem_wrt_en     = in_access & lat_we;
    assign bus.mem_address    = lat_addr;
    assign bus.mem_write_data = lat_wdata;
    assign bus.rsp0_valid     = rsp0_valid;
    assign bus.rsp1_valid     = rsp1_valid;
    assign bus.rsp0_rdata     = rsp0_rdata;
    assign bus.rsp1_rdata     = rsp1_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            last_grant <= REQ_LOADER;
            lat_we     <= 1'b0;
            lat_id     <= REQ_CORE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            state      <= state_nx;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;

            if (accept) begin
                lat_we     <= grant_id ? bus.req1_we    : bus.req0_we;
                lat_addr   <= grant_id ? bus.req1_addr  : bus.req0_addr;
                lat_wdata  <= grant_id ? bus.req1_wdata : bus.req0_wdata;
                lat_id     <= grant_id;
                last_grant <= grant_id;
            end

            if (in_access) begin
                if (lat_id == REQ_CORE) begin
                    rsp0_valid <= 1'b1;
                    rsp0_rdata <= lat_we ? '0 : bus.mem_read_data;
                end else begin
                    rsp1_valid <= 1'b1;
                    rsp1_rdata <= lat_we ? '0 : bus.mem_read_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Brief    : Directed and random stimulus against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_data_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam logic [63:0] ADDR_TOP  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ADDR_TOP1 = 64'hFFFF_FFFF_FFFF_FFFE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // data_mem: combinational read, write on the rising edge, zero-filled
    logic [63:0] dmem [logic [63:0]];
    int          mem_gen = 0;

    function automatic logic [63:0] dmem_rd(input logic [63:0] a);
        return dmem.exists(a) ? dmem[a] : 64'd0;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_wrt_en === 1'b1) begin
            dmem[bus.mem_address] = bus.mem_write_data;
            mem_gen = mem_gen + 1;
        end
    end

    always @(bus.mem_address or mem_gen) bus.mem_read_data = dmem_rd(bus.mem_address);

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: which port owns the memory this cycle,
    // which response is due, and what memory holds.
    logic [63:0] ref_mem [logic [63:0]];
    int          acc_port;
    logic        acc_we;
    logic [63:0] acc_addr, acc_wdata;
    int          rsp_port;
    logic [63:0] rsp_data;
    int          last_g;
    logic [63:0] shown_addr, shown_wdata;
    bit          took0, took1;

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 64'd0;
    endfunction

    task automatic model_reset();
        acc_port    = -1;
        rsp_port    = -1;
        last_g      = 1;
        shown_addr  = '0;
        shown_wdata = '0;
        took0       = 1'b0;
        took1       = 1'b0;
    endtask

    task automatic check_and_advance();
        int g;
        g = -1;
        if (acc_port < 0) begin
            if (bus.req0_valid && bus.req1_valid) g = 1 - last_g;
            else if (bus.req0_valid)              g = 0;
            else if (bus.req1_valid)              g = 1;
        end
        chk("req0_ready", bus.req0_ready, g == 0);
        chk("req1_ready", bus.req1_ready, g == 1);
        chk("busy", bus.busy, acc_port >= 0);
        chk("mem_wrt_en", bus.mem_wrt_en, (acc_port >= 0) && acc_we);
        chk("mem_address", bus.mem_address, shown_addr);
        chk("mem_write_data", bus.mem_write_data, shown_wdata);
        chk("rsp0_valid", bus.rsp0_valid, rsp_port == 0);
        chk("rsp1_valid", bus.rsp1_valid, rsp_port == 1);
        if (rsp_port == 0) chk("rsp0_rdata", bus.rsp0_rdata, rsp_data);
        if (rsp_port == 1) chk("rsp1_rdata", bus.rsp1_rdata, rsp_data);
        took0 = (g == 0);
        took1 = (g == 1);

        if (acc_port >= 0) begin
            rsp_port = acc_port;
            rsp_data = acc_we ? 64'd0 : ref_rd(acc_addr);
            if (acc_we) ref_mem[acc_addr] = acc_wdata;
            acc_port = -1;
        end else begin
            rsp_port = -1;
            if (g >= 0) begin
                acc_port    = g;
                acc_we      = (g == 1) ? bus.req1_we    : bus.req0_we;
                acc_addr    = (g == 1) ? bus.req1_addr  : bus.req0_addr;
                acc_wdata   = (g == 1) ? bus.req1_wdata : bus.req0_wdata;
                shown_addr  = acc_addr;
                shown_wdata = acc_wdata;
                last_g      = g;
            end
        end
    endtask

    // Inputs change at posedge+1; outputs are judged at the falling edge.
    task automatic cycle();
        @(negedge clk);
        check_and_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic we,
                           input logic [63:0] a, input logic [63:0] d);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
        end
    endtask

    task automatic issue(input int p, input logic we, input logic [63:0] a, input logic [63:0] d);
        bit done;
        done = 1'b0;
        set_req(p, 1'b1, we, a, d);
        for (int i = 0; i < 8 && !done; i++) begin
            cycle();
            done = (p == 0) ? took0 : took1;
        end
        chk("grant_timeout", done, 1'b1);
        set_req(p, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic logic [63:0] rnd_addr();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return 64'd8;
            2:       return 64'd22;
            3:       return 64'd44;
            4:       return ADDR_TOP1;
            5:       return ADDR_TOP;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        model_reset();
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk("rst_rsp0_rdata", bus.rsp0_rdata, 64'd0);
        chk("rst_rsp1_rdata", bus.rsp1_rdata, 64'd0);
        cycle();
        rst = 1'b1;
        cycle();

        // Single store from the loader, then read-back from the core
        issue(1, 1'b1, 64'd44, 64'h0000_0000_AAAA_FFFF);
        cycle(); cycle();
        issue(0, 1'b0, 64'd44, '0);
        cycle(); cycle();
        issue(0, 1'b0, 64'd22, '0);
        cycle(); cycle();

        // Continuous contention
        set_req(0, 1'b1, 1'b0, 64'd0, '0);
        set_req(1, 1'b1, 1'b0, 64'd44, '0);
        repeat (8) cycle();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        cycle(); cycle();

        // Boundary addresses
        issue(0, 1'b0, ADDR_TOP1, '0);
        cycle(); cycle();
        issue(0, 1'b0, ADDR_TOP, '0);
        cycle(); cycle();

        // Reset during the access cycle of a store
        issue(1, 1'b1, 64'd8, 64'h1234);
        #1 rst = 1'b0;
        #1;
        chk("abort_wrt_en", bus.mem_wrt_en, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_addr", bus.mem_address, 64'd0);
        chk("abort_wdata", bus.mem_write_data, 64'd0);
        chk("abort_rsp1", bus.rsp1_valid, 1'b0);
        model_reset();
        cycle();
        rst = 1'b1;
        cycle();
        issue(0, 1'b0, 64'd8, '0);
        cycle(); cycle();

        // Back-to-back loads from one port
        begin
            int n;
            n = 0;
            set_req(0, 1'b1, 1'b0, 64'd44, '0);
            for (int i = 0; i < 12 && n < 3; i++) begin
                cycle();
                if (took0) begin
                    n++;
                    bus.req0_addr = 64'd44 + 64'(n * 8);
                end
            end
            chk("b2b_count", 64'(n), 64'd3);
            set_req(0, 1'b0, 1'b0, '0, '0);
            cycle(); cycle();
        end

        // Random traffic; requesters hold until accepted, occasionally withdraw
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++) begin
                bit v, took;
                v    = (p == 0) ? bus.req0_valid : bus.req1_valid;
                took = (p == 0) ? took0 : took1;
                if (took || !v) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(p, 1'b1, 1'($urandom_range(0, 1)), rnd_addr(), {$urandom(), $urandom()});
                    else
                        set_req(p, 1'b0, 1'b0, '0, '0);
                end else if ($urandom_range(0, 15) == 0) begin
                    set_req(p, 1'b0, 1'b0, '0, '0);
                end
            end
            cycle();
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        cycle(); cycle(); cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and sequencer in front of the single-port `data_mem`. It grants one pending load/store at a time, using round-robin on conflict. It latches the winning request, drives the memory port for exactly one access cycle, and returns a one-cycle response pulse with the read data to the winner. Port 0 is the core load/store path. Port 1 is the loader/debug path that preloads and inspects data memory.

## Interface
Parameters:
- `ADDR_W`, 64: address width; matches `data_mem` address.
- `DATA_W`, 64: data width; matches `data_mem` write/read data.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: request pending.
- `req0_we` / `req1_we` in 1: 1 = store, 0 = load.
- `req0_addr` / `req1_addr` in ADDR_W: byte address, passed unmodified.
- `req0_wdata` / `req1_wdata` in DATA_W: store data.
- `req0_ready` / `req1_ready` out 1: request accepted this cycle.
- `rsp0_valid` / `rsp1_valid` out 1: one-cycle completion pulse.
- `rsp0_rdata` / `rsp1_rdata` out DATA_W: load data; 0 for stores.
- `mem_wrt_en` out 1: to `data_mem.wrt_en`.
- `mem_address` out ADDR_W: to `data_mem.address`.
- `mem_write_data` out DATA_W: to `data_mem.write_data`.
- `mem_read_data` in DATA_W: from `data_mem.read_data`; combinational in address.
- `busy` out 1: high in ARB_ACCESS.

## Operation
- FSM states are ARB_IDLE and ARB_ACCESS.
- **ARB_IDLE**
  - If no valid request, stay in ARB_IDLE.
  - If exactly one request is valid, grant it.
  - If both are valid, grant the requester ≠ `last_grant`.
  - The granted `reqN_ready` = 1 combinationally in the same cycle; the other ready = 0.
  - On that edge, latch we/addr/wdata and the grant id, update `last_grant`, and go to ARB_ACCESS.
- **ARB_ACCESS**
  - Drive `mem_address` and `mem_write_data` from the latched values; `mem_wrt_en` = latched we.
  - Both readies = 0.
  - On the edge, `data_mem` performs the write (if we). `rspN_valid` <= 1 for the granted id, and `rspN_rdata` <= `mem_read_data` for a load or 0 for a store. Return to ARB_IDLE.
- `rspN_valid` is high for exactly one cycle, which is the ARB_IDLE cycle after ARB_ACCESS. A new grant may occur in that same cycle.
- `mem_wrt_en` = 0 in every cycle outside ARB_ACCESS.
- `mem_address` and `mem_write_data` hold their last latched values in ARB_IDLE.
- Requesters hold valid/we/addr/wdata stable until they see ready. A dropped valid before ready is legal; no grant occurs.
- No address range checking or alignment: all 2^ADDR_W addresses are forwarded, including all-ones and all-ones-minus-one.

## Timing
- Reset (rst = 0, asynchronous):
  - State = ARB_IDLE, `last_grant` = 1 (port 0 wins the first conflict).
  - All latched registers = 0.
  - `mem_wrt_en`, `mem_address`, `mem_write_data` = 0.
  - All ready/rsp_valid/rdata/busy = 0.
- Latency is fixed: accept at cycle T (ready high), memory access at T+1, `rsp_valid` at T+2.
- Peak throughput is one access per 2 cycles. Under continuous contention the ports strictly alternate.
- Reset asserted in ARB_ACCESS aborts the access: `mem_wrt_en` falls immediately, no write is committed at the next edge, and no response is issued. The requester must reissue.
- A request arriving in ARB_ACCESS waits. It is eligible at the next ARB_IDLE cycle.

## Structure
- Package `data_mem_arb_pkg`:
  - typedef enum `arb_state_t` {ARB_IDLE, ARB_ACCESS}.
  - constants `REQ_CORE` = 0 and `REQ_LOADER` = 1.
  - default widths `ADDR_W` / `DATA_W` = 64.
- Sub-module `rr_arbiter2`: combinational 2-way round-robin pick, taking valid[1:0] and last_grant and producing grant id and grant_any. `last_grant` itself is held in `data_mem_arbiter`.
- Top instantiates `rr_arbiter2` plus the FSM and latch registers. The bench instantiates `data_mem_arbiter` with `data_mem` attached.

## Test plan
- Reset then single store: port 1 stores addr 44, data 0x00000000AAAAFFFF. Expect `req1_ready` at T, `mem_wrt_en` = 1 only at T+1, `rsp1_valid` at T+2 with rdata = 0.
- Read-back: port 0 loads addr 44, then addr 22. Expect `rsp0_rdata` = 0x00000000AAAAFFFF, then 0 (data_mem's reset contents).
- Conflict: both valid every cycle after reset; port 0 loads addr 0, port 1 loads addr 44. Expect grants 0,1,0,1 on alternating IDLE cycles and each rsp pulse on the correct port only.
- Boundary addresses: port 0 loads 64'hFFFF_FFFF_FFFF_FFFE, then 64'hFFFF_FFFF_FFFF_FFFF. Expect `mem_address` to equal each exactly during ARB_ACCESS, with no X on rsp.
- Reset mid-access: port 1 stores addr 8, data 0x1234. Drop rst during ARB_ACCESS. Expect no `rsp1_valid`, all outputs 0 immediately, and a subsequent load of addr 8 returning 0.
- Back-to-back single port: port 0 holds valid with 3 loads. Expect ready every 2nd cycle and `rsp0_valid` pulses 2 cycles apart.
